// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
// Shared definitions for the RAM port arbiter slice:
//   - requester ID constants (m0 = instruction fetch, m1 = load/store)
//   - FSM state type for the lock sequencer
//   - default address / data widths
package ram_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rr_arb2
// Combinational two-way round-robin grant.
//   req[1:0]  in   raw requests (bit 0 = m0, bit 1 = m1)
//   last      in   requester granted most recently (REQ_M0 / REQ_M1)
//   mask[1:0] in   1 = requester may be granted this cycle
//   gnt[1:0]  out  one-hot (or zero) grant
// On a tie the requester that was not granted last wins.
module rr_arb2
    import ram_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] eligible;

    always_comb begin
        eligible = req & mask;
        gnt      = 2'b00;
        if (eligible == 2'b11) begin
            gnt = (last == REQ_M1) ? 2'b01 : 2'b10;
        end else begin
            gnt = eligible;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares the single port of the block RAM (one-cycle registered read)
// between instruction fetch (m0) and load/store (m1).
//   clka, rsta_n              clock / asynchronous active-low reset
//   mX_req/we/addr/wdata      request side, held stable until granted
//   m1_lock                   keep the port for m1 after this access
//   mX_gnt                    combinational accept
//   mX_rvalid / mX_rdata      read response, one cycle after the transfer
//   ram_we/ram_addr/ram_din   RAM port drive
//   ram_dout                  RAM read data
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clka,
    input  logic              rsta_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              rvalid_q, rvalid_d;
    logic              rid_q, rid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;

    logic [1:0]        arb_mask;
    logic [1:0]        arb_gnt;
    logic              xfer;

    // While locked, m0 is masked off only as long as m1 keeps requesting;
    // once m1 drops its request the lock is void and m0 may take the port
    // in that same cycle.
    always_comb begin
        arb_mask = 2'b11;
        if (state_q == LOCK1 && m1_req) begin
            arb_mask = 2'b10;
        end
    end

    rr_arb2 u_rr_arb2 (
        .req  ({m1_req, m0_req}),
        .last (last_q),
        .mask (arb_mask),
        .gnt  (arb_gnt)
    );

    // No grants while reset is held, so nothing reaches the RAM.
    assign m0_gnt = arb_gnt[0] & rsta_n;
    assign m1_gnt = arb_gnt[1] & rsta_n;
    assign xfer   = m0_gnt | m1_gnt;

    // RAM port mux: address/data hold their last value when idle so the
    // RAM inputs do not toggle needlessly.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = addr_q;
        ram_din  = din_q;
        if (m0_gnt) begin
            ram_we   = m0_we;
            ram_addr = m0_addr;
            ram_din  = m0_wdata;
        end else if (m1_gnt) begin
            ram_we   = m1_we;
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
        end
        addr_d = ram_addr;
        din_d  = ram_din;
    end

    // Round-robin history and response tag.
    always_comb begin
        last_d   = last_q;
        rid_d    = rid_q;
        rvalid_d = xfer & ~ram_we;
        if (xfer) begin
            last_d = m1_gnt ? REQ_M1 : REQ_M0;
            rid_d  = m1_gnt ? REQ_M1 : REQ_M0;
        end
    end

    // Lock sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB: begin
                if (m1_gnt && m1_lock) begin
                    state_d = LOCK1;
                end
            end
            LOCK1: begin
                if (!m1_req) begin
                    state_d = ARB;
                end else if (m1_gnt && !m1_lock) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q  <= ARB;
            last_q   <= REQ_M1;
            rvalid_q <= 1'b0;
            rid_q    <= REQ_M0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
        end
    end

    // The RAM registers the read itself; both requesters see its output and
    // the tag selects which one is told it is valid.
    assign m0_rvalid = rvalid_q && (rid_q == REQ_M0);
    assign m1_rvalid = rvalid_q && (rid_q == REQ_M1);
    assign m0_rdata  = ram_dout;
    assign m1_rdata  = ram_dout;

endmodule
